// File: rtl/psg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// psg_pkg : register map, width masks and bus phase type for the PSG
// Rev 1.0
// ---------------------------------------------------------------------
package psg_pkg;

   localparam logic [3:0] REG_TONE_A_FINE   = 4'd0;
   localparam logic [3:0] REG_TONE_A_COARSE = 4'd1;
   localparam logic [3:0] REG_TONE_B_FINE   = 4'd2;
   localparam logic [3:0] REG_TONE_B_COARSE = 4'd3;
   localparam logic [3:0] REG_TONE_C_FINE   = 4'd4;
   localparam logic [3:0] REG_TONE_C_COARSE = 4'd5;
   localparam logic [3:0] REG_NOISE_PERIOD  = 4'd6;
   localparam logic [3:0] REG_MIXER         = 4'd7;
   localparam logic [3:0] REG_AMP_A         = 4'd8;
   localparam logic [3:0] REG_AMP_B         = 4'd9;
   localparam logic [3:0] REG_AMP_C         = 4'd10;
   localparam logic [3:0] REG_ENV_FINE      = 4'd11;
   localparam logic [3:0] REG_ENV_COARSE    = 4'd12;
   localparam logic [3:0] REG_ENV_SHAPE     = 4'd13;

   localparam logic [7:0] MASK_8B   = 8'hFF;
   localparam logic [7:0] MASK_5B   = 8'h1F;
   localparam logic [7:0] MASK_4B   = 8'h0F;
   localparam logic [7:0] MASK_NONE = 8'h00;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'b00,
      PH_READ  = 2'b01,
      PH_WRITE = 2'b10,
      PH_LATCH = 2'b11
   } bus_phase_t;

   // R14/R15 are the absent I/O ports: every bit masked off
   function automatic logic [7:0] reg_mask(input logic [3:0] addr);
      logic [7:0] m;
      m = MASK_NONE;
      case (addr)
         REG_TONE_A_FINE, REG_TONE_B_FINE, REG_TONE_C_FINE,
         REG_MIXER, REG_ENV_FINE, REG_ENV_COARSE:         m = MASK_8B;
         REG_TONE_A_COARSE, REG_TONE_B_COARSE,
         REG_TONE_C_COARSE, REG_ENV_SHAPE:                m = MASK_4B;
         REG_NOISE_PERIOD, REG_AMP_A, REG_AMP_B, REG_AMP_C: m = MASK_5B;
         default:                                         m = MASK_NONE;
      endcase
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/psg_bus_interface_bus_synchronizer.sv
`default_nettype none
// ---------------------------------------------------------------------
// bus_synchronizer : WIDTH-bit, SYNC_STAGES-deep flop chain
// Rev 1.0
// ---------------------------------------------------------------------
module bus_synchronizer #(
   parameter int WIDTH       = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [SYNC_STAGES];

   always_ff @(posedge clk) begin
      if (reset) chain[0] <= '0;
      else       chain[0] <= d;
   end

   for (genvar i = 1; i < SYNC_STAGES; i++) begin : g_stage
      always_ff @(posedge clk) begin
         if (reset) chain[i] <= '0;
         else       chain[i] <= chain[i-1];
      end
   end

   assign q = chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/psg_bus_interface.sv
`default_nettype none
// ---------------------------------------------------------------------
// psg_bus_interface : AY-3-8913 bus decode and register file
// Optional readback mux under macro PSG_READBACK_EN.  Rev 1.0
// ---------------------------------------------------------------------
module psg_bus_interface
   import psg_pkg::*;
#(
   parameter logic [3:0] CHIP_ADDR   = 4'h0,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bdir,
   input  logic        bc1,
   input  logic        cs_n,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic [11:0] tone_period_a,
   output logic [11:0] tone_period_b,
   output logic [11:0] tone_period_c,
   output logic [4:0]  noise_period,
   output logic [5:0]  mixer,
   output logic [4:0]  amp_a,
   output logic [4:0]  amp_b,
   output logic [4:0]  amp_c,
   output logic [15:0] env_period,
   output logic [3:0]  env_shape,
   output logic        env_restart
);

`ifdef PSG_READBACK_EN
   localparam int MIXER_BITS = 8;
`else
   localparam int MIXER_BITS = 6;
`endif

   logic [2:0] ctrl_s;
   logic [7:0] data_s;
   logic       bdir_s, bc1_s, cs_n_s;

   bus_synchronizer #(.WIDTH(3), .SYNC_STAGES(SYNC_STAGES)) u_sync_ctrl (
      .clk(clk), .reset(reset), .d({bdir, bc1, cs_n}), .q(ctrl_s)
   );
   bus_synchronizer #(.WIDTH(8), .SYNC_STAGES(SYNC_STAGES)) u_sync_data (
      .clk(clk), .reset(reset), .d(data_in), .q(data_s)
   );

   assign {bdir_s, bc1_s, cs_n_s} = ctrl_s;

   bus_phase_t state, next_state;
   logic       sample_en, latch_exit, commit;
   logic [7:0] sample;
   logic [3:0] addr;
   logic       addr_valid;
   logic       commit_pend;
   logic [3:0] commit_addr;
   logic [7:0] commit_data;

   always_ff @(posedge clk) begin
      if (reset) state <= PH_IDLE;
      else       state <= next_state;
   end

   // Leaving WRITE commits only while still selected; cs_n rising aborts
   always_comb begin
      next_state = PH_IDLE;
      sample_en  = 1'b0;
      latch_exit = 1'b0;
      commit     = 1'b0;
      if (!cs_n_s) begin
         case ({bdir_s, bc1_s})
`ifdef PSG_READBACK_EN
            2'b01:   next_state = PH_READ;
`endif
            2'b10:   next_state = PH_WRITE;
            2'b11:   next_state = PH_LATCH;
            default: next_state = PH_IDLE;
         endcase
      end
      sample_en  = (next_state == PH_LATCH) || (next_state == PH_WRITE);
      latch_exit = (state == PH_LATCH) && (next_state != PH_LATCH);
      commit     = (state == PH_WRITE) && (next_state != PH_WRITE) &&
                   !cs_n_s && addr_valid;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sample      <= '0;
         addr        <= '0;
         addr_valid  <= 1'b0;
         commit_pend <= 1'b0;
         commit_addr <= '0;
         commit_data <= '0;
      end else begin
         if (sample_en) sample <= data_s;
         if (latch_exit) begin
            addr       <= sample[3:0];
            addr_valid <= (sample[7:4] == CHIP_ADDR);
         end
         commit_pend <= commit;
         commit_addr <= addr;
         commit_data <= sample & reg_mask(addr);
      end
   end

   logic [7:0]            tone_a_fine, tone_b_fine, tone_c_fine;
   logic [3:0]            tone_a_coarse, tone_b_coarse, tone_c_coarse;
   logic [4:0]            noise_reg, amp_a_reg, amp_b_reg, amp_c_reg;
   logic [MIXER_BITS-1:0] mixer_reg;
   logic [7:0]            env_fine, env_coarse;
   logic [3:0]            shape_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         tone_a_fine   <= '0;
         tone_a_coarse <= '0;
         tone_b_fine   <= '0;
         tone_b_coarse <= '0;
         tone_c_fine   <= '0;
         tone_c_coarse <= '0;
         noise_reg     <= '0;
         mixer_reg     <= '0;
         amp_a_reg     <= '0;
         amp_b_reg     <= '0;
         amp_c_reg     <= '0;
         env_fine      <= '0;
         env_coarse    <= '0;
         shape_reg     <= '0;
         env_restart   <= 1'b0;
      end else begin
         env_restart <= 1'b0;
         if (commit_pend) begin
            case (commit_addr)
               REG_TONE_A_FINE:   tone_a_fine   <= commit_data;
               REG_TONE_A_COARSE: tone_a_coarse <= commit_data[3:0];
               REG_TONE_B_FINE:   tone_b_fine   <= commit_data;
               REG_TONE_B_COARSE: tone_b_coarse <= commit_data[3:0];
               REG_TONE_C_FINE:   tone_c_fine   <= commit_data;
               REG_TONE_C_COARSE: tone_c_coarse <= commit_data[3:0];
               REG_NOISE_PERIOD:  noise_reg     <= commit_data[4:0];
               REG_MIXER:         mixer_reg     <= commit_data[MIXER_BITS-1:0];
               REG_AMP_A:         amp_a_reg     <= commit_data[4:0];
               REG_AMP_B:         amp_b_reg     <= commit_data[4:0];
               REG_AMP_C:         amp_c_reg     <= commit_data[4:0];
               REG_ENV_FINE:      env_fine      <= commit_data;
               REG_ENV_COARSE:    env_coarse    <= commit_data;
               REG_ENV_SHAPE: begin
                  shape_reg   <= commit_data[3:0];
                  env_restart <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign tone_period_a = {tone_a_coarse, tone_a_fine};
   assign tone_period_b = {tone_b_coarse, tone_b_fine};
   assign tone_period_c = {tone_c_coarse, tone_c_fine};
   assign noise_period  = noise_reg;
   assign mixer         = mixer_reg[5:0];
   assign amp_a         = amp_a_reg;
   assign amp_b         = amp_b_reg;
   assign amp_c         = amp_c_reg;
   assign env_period    = {env_coarse, env_fine};
   assign env_shape     = shape_reg;

`ifdef PSG_READBACK_EN
   logic [7:0] read_mux;

   always_comb begin
      read_mux = '0;
      case (addr)
         REG_TONE_A_FINE:   read_mux = tone_a_fine;
         REG_TONE_A_COARSE: read_mux = {4'h0, tone_a_coarse};
         REG_TONE_B_FINE:   read_mux = tone_b_fine;
         REG_TONE_B_COARSE: read_mux = {4'h0, tone_b_coarse};
         REG_TONE_C_FINE:   read_mux = tone_c_fine;
         REG_TONE_C_COARSE: read_mux = {4'h0, tone_c_coarse};
         REG_NOISE_PERIOD:  read_mux = {3'h0, noise_reg};
         REG_MIXER:         read_mux = mixer_reg;
         REG_AMP_A:         read_mux = {3'h0, amp_a_reg};
         REG_AMP_B:         read_mux = {3'h0, amp_b_reg};
         REG_AMP_C:         read_mux = {3'h0, amp_c_reg};
         REG_ENV_FINE:      read_mux = env_fine;
         REG_ENV_COARSE:    read_mux = env_coarse;
         REG_ENV_SHAPE:     read_mux = {4'h0, shape_reg};
         default:           read_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out <= '0;
         data_oe  <= 1'b0;
      end else if ((next_state == PH_READ) && addr_valid) begin
         data_out <= read_mux;
         data_oe  <= 1'b1;
      end else begin
         data_out <= '0;
         data_oe  <= 1'b0;
      end
   end
`else
   assign data_out = '0;
   assign data_oe  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_psg_bus_interface.sv
`default_nettype none
// ---------------------------------------------------------------------
// tb_psg_bus_interface : directed bench for psg_bus_interface
// Readback section follows macro PSG_READBACK_EN.  Rev 1.0
// ---------------------------------------------------------------------
module tb_psg_bus_interface;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        bdir = 1'b0, bc1 = 1'b0, cs_n = 1'b1;
   logic [7:0]  data_in = 8'h00;
   logic [7:0]  data_out;
   logic        data_oe;
   logic [11:0] tone_period_a, tone_period_b, tone_period_c;
   logic [4:0]  noise_period;
   logic [5:0]  mixer;
   logic [4:0]  amp_a, amp_b, amp_c;
   logic [15:0] env_period;
   logic [3:0]  env_shape;
   logic        env_restart;

   int n_checks = 0;
   int n_errors = 0;
   int restart_count = 0;
   int rc0;

   psg_bus_interface #(.CHIP_ADDR(4'h0), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .bdir(bdir), .bc1(bc1), .cs_n(cs_n),
      .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
      .tone_period_a(tone_period_a), .tone_period_b(tone_period_b),
      .tone_period_c(tone_period_c), .noise_period(noise_period),
      .mixer(mixer), .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c),
      .env_period(env_period), .env_shape(env_shape),
      .env_restart(env_restart)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!reset && env_restart) restart_count <= restart_count + 1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic bus_phase(input logic b, input logic c, input logic cs,
                            input logic [7:0] d, input int n);
      @(negedge clk);
      bdir = b; bc1 = c; cs_n = cs; data_in = d;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic latch(input logic [7:0] a);
      bus_phase(1'b1, 1'b1, 1'b0, a, 3);
      bus_phase(1'b0, 1'b0, 1'b0, 8'h00, 2);
   endtask

   task automatic write(input logic [7:0] d);
      bus_phase(1'b1, 1'b0, 1'b0, d, 3);
      bus_phase(1'b0, 1'b0, 1'b0, 8'h00, 8);
   endtask

   task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
      latch({4'h0, a});
      write(d);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tone_a"}, 32'(tone_period_a), 32'h0);
      check({tag, "_tone_b"}, 32'(tone_period_b), 32'h0);
      check({tag, "_tone_c"}, 32'(tone_period_c), 32'h0);
      check({tag, "_noise"},  32'(noise_period),  32'h0);
      check({tag, "_mixer"},  32'(mixer),         32'h0);
      check({tag, "_amps"},   32'({amp_a, amp_b, amp_c}), 32'h0);
      check({tag, "_envper"}, 32'(env_period),    32'h0);
      check({tag, "_shape"},  32'(env_shape),     32'h0);
      check({tag, "_restart"}, 32'(env_restart),  32'h0);
      check({tag, "_dout"},   32'(data_out),      32'h0);
      check({tag, "_doe"},    32'(data_oe),       32'h0);
   endtask

   initial begin
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check_all_zero("reset");

      // R13 write: restart pulse exactly SYNC_STAGES+2 clocks after WRITE ends
      latch(8'h0D);
      bus_phase(1'b1, 1'b0, 1'b0, 8'h0E, 3);
      bus_phase(1'b0, 1'b0, 1'b0, 8'h00, 1);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         check($sformatf("restart_edge%0d", k), 32'(env_restart),
               (k == 4) ? 32'h1 : 32'h0);
         if (k == 3) check("shape_before", 32'(env_shape), 32'h0);
         if (k == 4) check("shape_after", 32'(env_shape), 32'hE);
      end

      write_reg(4'd1, 8'hFF);
      check("tone_a_coarse_mask", 32'(tone_period_a), 32'hF00);
      write_reg(4'd0, 8'h5A);
      check("tone_a_full", 32'(tone_period_a), 32'hF5A);
      write_reg(4'd6, 8'hFF);
      check("noise_mask", 32'(noise_period), 32'h1F);
      write(8'h03);
      check("noise_rewrite", 32'(noise_period), 32'h03);
      write_reg(4'd7, 8'hFF);
      check("mixer_mask", 32'(mixer), 32'h3F);
      write_reg(4'd9, 8'hFF);
      check("amp_b_mask", 32'(amp_b), 32'h1F);
      write_reg(4'd10, 8'h0A);
      check("amp_c", 32'(amp_c), 32'h0A);
      write_reg(4'd5, 8'hC7);
      check("tone_c", 32'(tone_period_c), 32'h700);

      write_reg(4'd11, 8'h34);
      write_reg(4'd12, 8'h12);
      check("env_period", 32'(env_period), 32'h1234);

      rc0 = restart_count;
      write_reg(4'd13, 8'h0E);
      check("restart_rewrite", 32'(restart_count), 32'(rc0 + 1));
      check("shape_rewrite", 32'(env_shape), 32'hE);

      // Wrong chip address: nothing may change
      rc0 = restart_count;
      latch(8'h1B);
      write(8'h55);
      check("mismatch_envper", 32'(env_period), 32'h1234);
      latch(8'h1D);
      write(8'h03);
      check("mismatch_shape", 32'(env_shape), 32'hE);
      check("mismatch_restart", 32'(restart_count), 32'(rc0));

      // cs_n abort mid-write
      write_reg(4'd8, 8'h1F);
      check("amp_a", 32'(amp_a), 32'h1F);
      latch(8'h08);
      bus_phase(1'b1, 1'b0, 1'b0, 8'h03, 3);
      bus_phase(1'b1, 1'b0, 1'b1, 8'h03, 3);
      bus_phase(1'b0, 1'b0, 1'b1, 8'h00, 8);
      check("abort_amp_a", 32'(amp_a), 32'h1F);

`ifdef PSG_READBACK_EN
      write_reg(4'd1, 8'hAB);
      check("tone_a_rewrite", 32'(tone_period_a), 32'hB5A);
      bus_phase(1'b0, 1'b1, 1'b0, 8'h00, 4);
      check("read_r1_data", 32'(data_out), 32'h0B);
      check("read_r1_oe", 32'(data_oe), 32'h1);
      bus_phase(1'b0, 1'b0, 1'b0, 8'h00, 4);
      check("idle_data", 32'(data_out), 32'h0);
      check("idle_oe", 32'(data_oe), 32'h0);
      write_reg(4'd14, 8'hFF);
      bus_phase(1'b0, 1'b1, 1'b0, 8'h00, 4);
      check("read_r14_data", 32'(data_out), 32'h0);
      bus_phase(1'b0, 1'b0, 1'b0, 8'h00, 4);
`else
      latch(8'h01);
      bus_phase(1'b0, 1'b1, 1'b0, 8'h00, 4);
      check("noread_data", 32'(data_out), 32'h0);
      check("noread_oe", 32'(data_oe), 32'h0);
      bus_phase(1'b0, 1'b0, 1'b0, 8'h00, 4);
`endif

      // Reset in the middle of a write: no commit, everything cleared
      latch(8'h09);
      bus_phase(1'b1, 1'b0, 1'b0, 8'h05, 3);
      @(negedge clk);
      reset = 1'b1; bdir = 1'b0; cs_n = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      check_all_zero("midwrite_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
